// File: rtl/floating_point_to_integer_converter_pkg.sv
// Shared types and constant helpers for the float-to-integer converter.
// Contents: FSM state enum, float classification enum, exponent-bias
// function, saturation-constant functions and the special-value classifier.
package floating_point_to_integer_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_FINITE = 2'd0,
        FC_ZERO   = 2'd1,
        FC_INF    = 2'd2,
        FC_NAN    = 2'd3
    } float_class_e;

    // Wide enough for any integer width the converter is built with.
    localparam int unsigned SAT_W = 128;

    function automatic int unsigned float_bias(input int unsigned exponent_width);
        return (32'd1 << (exponent_width - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [SAT_W-1:0] signed_max(input int unsigned width);
        return (SAT_W'(1) << (width - 32'd1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] signed_min(input int unsigned width);
        return SAT_W'(1) << (width - 32'd1);
    endfunction

    function automatic logic [SAT_W-1:0] unsigned_max(input int unsigned width);
        return (SAT_W'(1) << width) - SAT_W'(1);
    endfunction

    // Classifies a float from its field summaries; subnormals count as finite.
    function automatic float_class_e is_special_float(input logic exp_zero,
                                                      input logic exp_ones,
                                                      input logic man_zero);
        float_class_e cls;
        cls = FC_FINITE;
        if (exp_ones) begin
            cls = man_zero ? FC_INF : FC_NAN;
        end else if (exp_zero && man_zero) begin
            cls = FC_ZERO;
        end
        return cls;
    endfunction

endpackage

// File: rtl/floating_point_to_integer_converter_rounder.sv
// float_to_int_rounder: combinational rounding and range check for the
// ROUND stage of the float-to-integer converter.
// Ports:
//   magnitude  aligned integer magnitude
//   guard      first discarded bit
//   sticky     OR of all bits below guard
//   sign       operand sign
//   is_signed  1 = signed result, 0 = unsigned result
//   mode       1 = round-to-nearest-even, 0 = truncate
//   out        final integer (saturated where needed)
//   overflow   magnitude did not fit and was saturated
//   invalid    negative nonzero value requested as unsigned
//   inexact    a nonzero fraction was discarded
module float_to_int_rounder
    import floating_point_to_integer_converter_pkg::*;
#(
    parameter int unsigned MAGNITUDE_WIDTH = 33,
    parameter int unsigned INTEGER_WIDTH   = 32
) (
    input  logic [MAGNITUDE_WIDTH-1:0] magnitude,
    input  logic                       guard,
    input  logic                       sticky,
    input  logic                       sign,
    input  logic                       is_signed,
    input  logic                       mode,
    output logic [INTEGER_WIDTH-1:0]   out,
    output logic                       overflow,
    output logic                       invalid,
    output logic                       inexact
);

    localparam int unsigned MAG_W = MAGNITUDE_WIDTH;
    localparam int unsigned INT_W = INTEGER_WIDTH;

    localparam logic [MAG_W-1:0] POS_LIMIT = MAG_W'(signed_max(INT_W));
    localparam logic [MAG_W-1:0] NEG_LIMIT = MAG_W'(signed_min(INT_W));
    localparam logic [MAG_W-1:0] UNS_LIMIT = MAG_W'(unsigned_max(INT_W));
    localparam logic [INT_W-1:0] SMAX      = INT_W'(signed_max(INT_W));
    localparam logic [INT_W-1:0] SMIN      = INT_W'(signed_min(INT_W));
    localparam logic [INT_W-1:0] UMAX      = INT_W'(unsigned_max(INT_W));

    logic             round_up;
    logic [MAG_W-1:0] rounded;

    // Ties go to the even magnitude; the extra top bit absorbs the carry.
    assign round_up = mode & guard & (sticky | magnitude[0]);
    assign rounded  = magnitude + MAG_W'(round_up);

    // Range check and sign application; overflow suppresses inexact.
    always_comb begin
        out      = sign ? INT_W'(MAG_W'(0) - rounded) : INT_W'(rounded);
        overflow = 1'b0;
        invalid  = 1'b0;
        inexact  = guard | sticky;
        if (is_signed) begin
            if (!sign && (rounded > POS_LIMIT)) begin
                out      = SMAX;
                overflow = 1'b1;
                inexact  = 1'b0;
            end else if (sign && (rounded > NEG_LIMIT)) begin
                out      = SMIN;
                overflow = 1'b1;
                inexact  = 1'b0;
            end
        end else if (sign) begin
            if (rounded != '0) begin
                out     = '0;
                invalid = 1'b1;
            end
        end else if (rounded > UNS_LIMIT) begin
            out      = UMAX;
            overflow = 1'b1;
            inexact  = 1'b0;
        end
    end

endmodule

// File: rtl/floating_point_to_integer_converter.sv
// Iterative float-to-integer converter: classifies the operand at capture,
// aligns the significand one bit per cycle, then rounds and range-checks.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake (a, is_signed)
//   out_valid / out_ready    result handshake (out and flags)
//   invalid_operation_flag   NaN, Inf, or negative value to unsigned
//   overflow_flag            finite value saturated
//   inexact_flag             nonzero fraction discarded
module floating_point_to_integer_converter
    import floating_point_to_integer_converter_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned INTEGER_WIDTH    = 32,
    parameter int unsigned ROUND_TO_NEAREST = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  a,
    input  logic                                    is_signed,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [INTEGER_WIDTH-1:0]                out,
    output logic                                    invalid_operation_flag,
    output logic                                    overflow_flag,
    output logic                                    inexact_flag
);

    localparam int unsigned FLOAT_W   = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int unsigned SIG_W     = MANTISSA_WIDTH + 1;
    localparam int unsigned MAG_W     = ((INTEGER_WIDTH > SIG_W) ? INTEGER_WIDTH : SIG_W) + 1;
    localparam int unsigned CNT_MAX   = (MANTISSA_WIDTH + 2 > INTEGER_WIDTH) ? MANTISSA_WIDTH + 2
                                                                             : INTEGER_WIDTH;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int          BIAS      = int'(float_bias(EXPONENT_WIDTH));
    localparam int          MAN_I     = int'(MANTISSA_WIDTH);
    localparam int          RIGHT_CAP = MAN_I + 2;
    localparam logic        RNE_MODE  = (ROUND_TO_NEAREST != 0);
    localparam logic [INTEGER_WIDTH-1:0] SMAX = INTEGER_WIDTH'(signed_max(INTEGER_WIDTH));
    localparam logic [INTEGER_WIDTH-1:0] SMIN = INTEGER_WIDTH'(signed_min(INTEGER_WIDTH));
    localparam logic [INTEGER_WIDTH-1:0] UMAX = INTEGER_WIDTH'(unsigned_max(INTEGER_WIDTH));

    state_e                     state, state_n;
    logic [MAG_W-1:0]           mag, mag_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic                       guard, guard_n;
    logic                       sticky, sticky_n;
    logic                       sign_q, sign_n;
    logic                       signed_q, signed_n;
    logic                       shift_left, shift_left_n;
    logic [INTEGER_WIDTH-1:0]   out_n;
    logic                       inv_n, ovf_n, inx_n;

    logic                       a_sign;
    logic [EXPONENT_WIDTH-1:0]  exp_field;
    logic [MANTISSA_WIDTH-1:0]  man_field;
    logic                       exp_zero;
    float_class_e               a_class;
    logic [SIG_W-1:0]           significand;
    int                         exp_unb;
    int                         right_raw;
    int                         right_amt;
    logic                       go_left;
    logic [INTEGER_WIDTH-1:0]   sat_value;

    logic [INTEGER_WIDTH-1:0]   rnd_out;
    logic                       rnd_ovf, rnd_inv, rnd_inx;

    // Operand decode; subnormals reuse the minimum exponent with no hidden bit.
    assign a_sign      = a[FLOAT_W-1];
    assign exp_field   = a[FLOAT_W-2 -: EXPONENT_WIDTH];
    assign man_field   = a[MANTISSA_WIDTH-1:0];
    assign exp_zero    = (exp_field == '0);
    assign a_class     = is_special_float(exp_zero, &exp_field, man_field == '0);
    assign significand = {~exp_zero, man_field};
    assign exp_unb     = exp_zero ? (1 - BIAS) : (int'(exp_field) - BIAS);
    assign right_raw   = MAN_I - exp_unb;
    assign right_amt   = (right_raw > RIGHT_CAP) ? RIGHT_CAP : right_raw;
    assign go_left     = (exp_unb > MAN_I);
    assign sat_value   = is_signed ? (a_sign ? SMIN : SMAX) : (a_sign ? '0 : UMAX);

    float_to_int_rounder #(
        .MAGNITUDE_WIDTH (MAG_W),
        .INTEGER_WIDTH   (INTEGER_WIDTH)
    ) u_rounder (
        .magnitude (mag),
        .guard     (guard),
        .sticky    (sticky),
        .sign      (sign_q),
        .is_signed (signed_q),
        .mode      (RNE_MODE),
        .out       (rnd_out),
        .overflow  (rnd_ovf),
        .invalid   (rnd_inv),
        .inexact   (rnd_inx)
    );

    // Next-state and next-datapath logic.
    always_comb begin
        state_n      = state;
        mag_n        = mag;
        cnt_n        = cnt;
        guard_n      = guard;
        sticky_n     = sticky;
        sign_n       = sign_q;
        signed_n     = signed_q;
        shift_left_n = shift_left;
        out_n        = out;
        inv_n        = invalid_operation_flag;
        ovf_n        = overflow_flag;
        inx_n        = inexact_flag;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_n       = a_sign;
                    signed_n     = is_signed;
                    mag_n        = '0;
                    cnt_n        = '0;
                    guard_n      = 1'b0;
                    sticky_n     = 1'b0;
                    shift_left_n = 1'b0;
                    out_n        = '0;
                    inv_n        = 1'b0;
                    ovf_n        = 1'b0;
                    inx_n        = 1'b0;
                    case (a_class)
                        FC_NAN: begin
                            out_n   = is_signed ? SMAX : UMAX;
                            inv_n   = 1'b1;
                            state_n = DONE;
                        end
                        FC_INF: begin
                            out_n   = sat_value;
                            inv_n   = 1'b1;
                            state_n = DONE;
                        end
                        FC_ZERO: state_n = DONE;
                        default: begin
                            if (exp_unb >= int'(INTEGER_WIDTH)) begin
                                out_n   = sat_value;
                                ovf_n   = 1'b1;
                                state_n = DONE;
                            end else begin
                                mag_n        = MAG_W'(significand);
                                shift_left_n = go_left;
                                cnt_n        = go_left ? CNT_W'(exp_unb - MAN_I) : CNT_W'(right_amt);
                                state_n      = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                // Last shift happens in the cycle that sees count==1; count 0 just passes through.
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                    if (shift_left) begin
                        mag_n = mag << 1;
                    end else begin
                        mag_n    = mag >> 1;
                        guard_n  = mag[0];
                        sticky_n = sticky | guard;
                    end
                end
                if (cnt <= CNT_W'(1)) begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                out_n   = rnd_out;
                inv_n   = rnd_inv;
                ovf_n   = rnd_ovf;
                inx_n   = rnd_inx;
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            mag                    <= '0;
            cnt                    <= '0;
            guard                  <= 1'b0;
            sticky                 <= 1'b0;
            sign_q                 <= 1'b0;
            signed_q               <= 1'b0;
            shift_left             <= 1'b0;
            in_ready               <= 1'b1;
            out_valid              <= 1'b0;
            out                    <= '0;
            invalid_operation_flag <= 1'b0;
            overflow_flag          <= 1'b0;
            inexact_flag           <= 1'b0;
        end else begin
            state                  <= state_n;
            mag                    <= mag_n;
            cnt                    <= cnt_n;
            guard                  <= guard_n;
            sticky                 <= sticky_n;
            sign_q                 <= sign_n;
            signed_q               <= signed_n;
            shift_left             <= shift_left_n;
            in_ready               <= (state_n == IDLE);
            out_valid              <= (state_n == DONE);
            out                    <= out_n;
            invalid_operation_flag <= inv_n;
            overflow_flag          <= ovf_n;
            inexact_flag           <= inx_n;
        end
    end

endmodule

// File: tb/tb_floating_point_to_integer_converter.sv
// Bench for floating_point_to_integer_converter: one round-to-nearest-even
// instance and one truncating instance share the same stimulus.
module tb_floating_point_to_integer_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        is_signed;
    logic        out_ready;
    logic [31:0] a;

    logic        in_ready_r, out_valid_r, inv_r, ovf_r, inx_r;
    logic [31:0] out_r;
    logic        in_ready_t, out_valid_t, inv_t, ovf_t, inx_t;
    logic [31:0] out_t;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [31:0] op;
        bit          sgn;
        logic [31:0] o_rne;
        logic [2:0]  f_rne;
        logic [31:0] o_trc;
        logic [2:0]  f_trc;
        int          lat;
    } vec_t;

    vec_t vq[$];

    floating_point_to_integer_converter #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INTEGER_WIDTH(32), .ROUND_TO_NEAREST(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .a(a), .is_signed(is_signed), .out_valid(out_valid_r), .out_ready(out_ready),
        .out(out_r), .invalid_operation_flag(inv_r), .overflow_flag(ovf_r),
        .inexact_flag(inx_r)
    );

    floating_point_to_integer_converter #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INTEGER_WIDTH(32), .ROUND_TO_NEAREST(0)
    ) dut_trc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .a(a), .is_signed(is_signed), .out_valid(out_valid_t), .out_ready(out_ready),
        .out(out_t), .invalid_operation_flag(inv_t), .overflow_flag(ovf_t),
        .inexact_flag(inx_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat(input bit s, input bit sgn);
        if (sgn) return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s ? 32'h0000_0000 : 32'hFFFF_FFFF;
    endfunction

    // Reference: exact value = sig * 2^(e-23), split into integer part and remainder.
    function automatic void ref_model(input logic [31:0] f, input bit sgn, input bit rne,
                                      output logic [31:0] o, output logic [2:0] fl,
                                      output int lat);
        bit     s;
        int     ex, e, c, sh;
        longint sig, ip, rem, half, v;
        bit     up, inx;
        s   = f[31];
        ex  = int'(f[30:23]);
        sig = longint'(f[22:0]);
        up  = 1'b0;
        inx = 1'b0;
        if (ex == 255) begin
            lat = 1;
            fl  = 3'b100;
            o   = (sig != 0) ? (sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF) : sat(s, sgn);
            return;
        end
        if (ex == 0 && sig == 0) begin
            lat = 1; fl = 3'b000; o = 32'h0;
            return;
        end
        if (ex == 0) e = -126;
        else begin
            e   = ex - 127;
            sig = sig + 64'd8388608;
        end
        if (e >= 32) begin
            lat = 1; fl = 3'b010; o = sat(s, sgn);
            return;
        end
        c   = (e > 23) ? e - 23 : ((23 - e > 25) ? 25 : 23 - e);
        lat = ((c == 0) ? 1 : c) + 2;
        if (e >= 23) begin
            ip = sig << (e - 23);
        end else begin
            sh = 23 - e;
            if (sh >= 25) begin
                ip  = 0;
                inx = 1'b1;
            end else begin
                ip   = sig >> sh;
                rem  = sig - (ip << sh);
                half = 64'd1 << (sh - 1);
                inx  = (rem != 0);
                up   = rne && ((rem > half) || (rem == half && ip[0]));
            end
        end
        if (up) ip = ip + 1;
        v = s ? -ip : ip;
        if (sgn) begin
            if (v > 64'sd2147483647)       begin o = 32'h7FFF_FFFF; fl = 3'b010; end
            else if (v < -64'sd2147483648) begin o = 32'h8000_0000; fl = 3'b010; end
            else                           begin o = 32'(v); fl = {2'b00, inx}; end
        end else begin
            if (v < 0)                     begin o = 32'h0; fl = {1'b1, 1'b0, inx}; end
            else if (v > 64'sd4294967295)  begin o = 32'hFFFF_FFFF; fl = 3'b010; end
            else                           begin o = 32'(v); fl = {2'b00, inx}; end
        end
    endfunction

    function automatic void add_vec(input logic [31:0] op, input bit sgn,
                                    input logic [31:0] o_rne, input logic [2:0] f_rne,
                                    input logic [31:0] o_trc, input logic [2:0] f_trc,
                                    input int lat);
        vec_t v;
        v.op = op; v.sgn = sgn; v.o_rne = o_rne; v.f_rne = f_rne;
        v.o_trc = o_trc; v.f_trc = f_trc; v.lat = lat;
        vq.push_back(v);
    endfunction

    // Present an operand and return at the falling edge after it is accepted.
    task automatic send(input logic [31:0] op, input bit sgn);
        int n;
        n = 0;
        @(negedge clk);
        a = op; is_signed = sgn; in_valid = 1'b1;
        while (!in_ready_r && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid_r && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [31:0] op, input bit sgn,
                             input logic [31:0] eo_r, input logic [2:0] ef_r,
                             input logic [31:0] eo_t, input logic [2:0] ef_t, input int elat);
        int lat;
        send(op, sgn);
        wait_result(lat);
        check($sformatf("%s_%08h_s%0d_latency", tag, op, sgn), 64'(lat), 64'(elat));
        check($sformatf("%s_%08h_s%0d_out_rne", tag, op, sgn), 64'(out_r), 64'(eo_r));
        check($sformatf("%s_%08h_s%0d_flags_rne", tag, op, sgn), 64'({inv_r, ovf_r, inx_r}), 64'(ef_r));
        check($sformatf("%s_%08h_s%0d_valid_trc", tag, op, sgn), 64'(out_valid_t), 64'd1);
        check($sformatf("%s_%08h_s%0d_out_trc", tag, op, sgn), 64'(out_t), 64'(eo_t));
        check($sformatf("%s_%08h_s%0d_flags_trc", tag, op, sgn), 64'({inv_t, ovf_t, inx_t}), 64'(ef_t));
        pop();
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [31:0] op, eo_r, eo_t;
        logic [2:0]  ef_r, ef_t;
        int          elat, elat_t;
        logic [7:0]  ex;
        logic [22:0] man;
        bit          sgn;

        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0; a = '0;

        // Flags packed as {invalid, overflow, inexact}.
        add_vec(32'h40490FDB, 1, 32'h0000_0003, 3'b001, 32'h0000_0003, 3'b001, 24);
        add_vec(32'hC0600000, 1, 32'hFFFF_FFFC, 3'b001, 32'hFFFF_FFFD, 3'b001, 24);
        add_vec(32'h4F000000, 1, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 3'b010, 10);
        add_vec(32'h4F000000, 0, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b000, 10);
        add_vec(32'hCF000000, 1, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b000, 10);
        add_vec(32'h7FC00000, 1, 32'h7FFF_FFFF, 3'b100, 32'h7FFF_FFFF, 3'b100, 1);
        add_vec(32'h7FC00000, 0, 32'hFFFF_FFFF, 3'b100, 32'hFFFF_FFFF, 3'b100, 1);
        add_vec(32'hBF000000, 0, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001, 26);
        add_vec(32'hBFC00000, 0, 32'h0000_0000, 3'b101, 32'h0000_0000, 3'b101, 25);
        add_vec(32'h3F800000, 1, 32'h0000_0001, 3'b000, 32'h0000_0001, 3'b000, 25);
        add_vec(32'hFF800000, 0, 32'h0000_0000, 3'b100, 32'h0000_0000, 3'b100, 1);
        add_vec(32'hFF800000, 1, 32'h8000_0000, 3'b100, 32'h8000_0000, 3'b100, 1);
        add_vec(32'h7F800000, 1, 32'h7FFF_FFFF, 3'b100, 32'h7FFF_FFFF, 3'b100, 1);
        add_vec(32'h80000000, 1, 32'h0000_0000, 3'b000, 32'h0000_0000, 3'b000, 1);
        add_vec(32'h4B000001, 1, 32'h0080_0001, 3'b000, 32'h0080_0001, 3'b000, 3);
        add_vec(32'h5F000000, 1, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 3'b010, 1);
        add_vec(32'hDF000000, 0, 32'h0000_0000, 3'b010, 32'h0000_0000, 3'b010, 1);
        add_vec(32'h00000001, 1, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001, 27);
        add_vec(32'h3FC00000, 1, 32'h0000_0002, 3'b001, 32'h0000_0001, 3'b001, 25);
        add_vec(32'h3F000000, 1, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001, 26);
        add_vec(32'h4F800000, 0, 32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 3'b010, 1);
        add_vec(32'h4F7FFFFF, 0, 32'hFFFF_FF00, 3'b000, 32'hFFFF_FF00, 3'b000, 10);
        add_vec(32'hCF000001, 1, 32'h8000_0000, 3'b010, 32'h8000_0000, 3'b010, 10);

        // Reset state.
        #22;
        check("reset_in_ready", 64'(in_ready_r), 64'd1);
        check("reset_out_valid", 64'(out_valid_r), 64'd0);
        check("reset_out", 64'(out_r), 64'd0);
        check("reset_flags", 64'({inv_r, ovf_r, inx_r}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            run_check("vec", vq[i].op, vq[i].sgn, vq[i].o_rne, vq[i].f_rne,
                      vq[i].o_trc, vq[i].f_trc, vq[i].lat);
        end

        // Result held while downstream stalls.
        send(32'h7FC00000, 1'b1);
        wait_result(lat);
        check("hold_latency", 64'(lat), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold_out_%0d", k), 64'(out_r), 64'h7FFF_FFFF);
            check($sformatf("hold_flags_%0d", k), 64'({inv_r, ovf_r, inx_r}), 64'b100);
            check($sformatf("hold_valid_%0d", k), 64'(out_valid_r), 64'd1);
            check($sformatf("hold_in_ready_%0d", k), 64'(in_ready_r), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", 64'(in_ready_r), 64'd1);
        check("release_out_valid", 64'(out_valid_r), 64'd0);

        // Reset while shifting aborts the operand.
        send(32'h4B000001, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid_r), 64'd0);
        check("abort_in_ready", 64'(in_ready_r), 64'd1);
        check("abort_out", 64'(out_r), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid_r || out_valid_t) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        check("abort_ready_after", 64'(in_ready_r), 64'd1);
        run_check("after_abort", 32'h3F800000, 1'b1, 32'h1, 3'b000, 32'h1, 3'b000, 25);

        // Randomized operands against the reference model.
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0:       ex = 8'hFF;
                1:       ex = 8'h00;
                2:       ex = 8'($urandom);
                default: ex = 8'($urandom_range(110, 160));
            endcase
            man = 23'($urandom);
            if ($urandom_range(0, 3) == 0) man = man & 23'h7F0000;
            if ($urandom_range(0, 7) == 0) man = 23'h0;
            op  = {1'($urandom), ex, man};
            sgn = 1'($urandom);
            ref_model(op, sgn, 1'b1, eo_r, ef_r, elat);
            ref_model(op, sgn, 1'b0, eo_t, ef_t, elat_t);
            run_check("rand", op, sgn, eo_r, ef_r, eo_t, ef_t, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
